gate_ctrl: RTL
==============

GATE_CTRL -- requirements
Module: gate_ctrl

Interface
REQ-001 Parameter GATE0, default 50_000_000: gate length in clk cycles for range 0 (1 s at 50 MHz).
REQ-002 Parameter GATE1, default 5_000_000: gate length in clk cycles for range 1 (0.1 s).
REQ-003 Parameter GATE2, default 500_000: gate length in clk cycles for range 2 (0.01 s).
REQ-004 Parameter CLR_CYC, default 4: counter-clear pulse width in cycles, minimum 1.
REQ-005 Parameter LAT_CYC, default 4: latch strobe width in cycles, minimum 1.
REQ-006 clk  in  1  system clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 run  in  1  level; high enables continuous measurement cycles.
REQ-009 range_sel  in  2  requested gate range; 3 is treated as 0.
REQ-010 cnt_clr  out  1  synchronous clear to the decade counter chain.
REQ-011 cnt_en  out  1  gate window; counters count the input signal only while high.
REQ-012 latch_out  out  1  strobe to the result latch; rising edge captures counts and overflow.
REQ-013 range_out  out  2  range of the most recently latched result, for decimal-point display.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse per completed measurement.

Function
REQ-016 States SHALL be IDLE, CLEAR, GATE, SETTLE and LATCH, held in registers; all outputs SHALL be registered or decoded from state only.
REQ-017 IDLE: all strobes are low; run=1 moves to CLEAR on the next cycle.
REQ-018 CLEAR: cnt_clr=1 for exactly CLR_CYC cycles; range_sel is sampled into an internal active-range register on CLEAR entry; then the block moves to GATE.
REQ-019 GATE: cnt_en=1 for exactly GATEn cycles, where n is the active range; a gate-cycle counter of at least 26 bits counts 0..GATEn-1; the active range SHALL NOT change during GATE.
REQ-020 SETTLE: exactly 1 cycle with cnt_en=0, cnt_clr=0, latch_out=0, so counter ripple completes before capture.
REQ-021 LATCH: latch_out=1 for exactly LAT_CYC cycles; range_out takes the active range on LATCH entry; done=1 on the last LATCH cycle only.
REQ-022 After LATCH the block moves to CLEAR if run=1, otherwise to IDLE.
REQ-023 Exactly one of cnt_clr, cnt_en and latch_out SHALL be high in any cycle, or none.
REQ-024 If run falls during CLEAR or GATE, the block SHALL abort to IDLE on the next cycle: cnt_en drops, no latch_out and no done; range_out keeps its value.
REQ-025 If run falls during SETTLE or LATCH, the current measurement SHALL complete, then the block moves to IDLE.
REQ-026 A range_sel change outside CLEAR entry SHALL take effect only at the next CLEAR entry.
REQ-027 Measurement period SHALL be CLR_CYC+GATEn+1+LAT_CYC cycles with run held high.

Reset
REQ-028 While rst=1, state SHALL be IDLE; cnt_clr, cnt_en, latch_out and done SHALL be 0; range_out and the active range SHALL be 0; the gate counter SHALL be 0.
REQ-029 rst asserted in any state SHALL force these values immediately, without waiting for clk.
REQ-030 After rst falls with run=1, the first CLEAR SHALL begin on the second rising clk edge.

Verification (GATE0=100, GATE1=10, GATE2=3, CLR_CYC=2, LAT_CYC=2)
REQ-031 run=1, range_sel=0: cnt_clr high 2 cycles, cnt_en high exactly 100, 1 idle cycle, latch_out high 2, done on 2nd; period 105.
REQ-032 range_sel=2 held: cnt_en width 3; range_out=2 from the first LATCH cycle; range_sel=3 gives width 100 and range_out=0.
REQ-033 range_sel changed 0->1 mid-GATE: current gate stays 100 cycles; the next gate is 10 cycles.
REQ-034 run dropped at gate cycle 50: cnt_en low the next cycle, no latch_out or done, busy=0, range_out unchanged.
REQ-035 run dropped in the first LATCH cycle: LATCH completes with done pulse, then IDLE and no further cnt_clr.
REQ-036 rst pulsed mid-GATE between clock edges: all outputs 0 immediately; run still 1 restarts CLEAR after release.

Source files
------------

// File: rtl/gate_ctrl.sv
// rtl/gate_ctrl.sv - frequency-counter gate sequencer: clear, gate, settle, latch
module gate_ctrl #(
  parameter int GATE0   = 50_000_000,
  parameter int GATE1   = 5_000_000,
  parameter int GATE2   = 500_000,
  parameter int CLR_CYC = 4,
  parameter int LAT_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [1:0] range_sel,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic       latch_out,
  output logic [1:0] range_out,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = 26;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_CYC - 1);
  localparam logic [CNT_W-1:0] G0_LAST  = CNT_W'(GATE0 - 1);
  localparam logic [CNT_W-1:0] G1_LAST  = CNT_W'(GATE1 - 1);
  localparam logic [CNT_W-1:0] G2_LAST  = CNT_W'(GATE2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] gate_last;
  logic [1:0]       act_range;
  // Holds IDLE for one extra edge after reset release so the first CLEAR
  // starts on the second rising edge.
  logic             rst_hold;

  always_comb begin
    gate_last = G0_LAST;
    case (act_range)
      2'd1:    gate_last = G1_LAST;
      2'd2:    gate_last = G2_LAST;
      default: gate_last = G0_LAST;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (run && !rst_hold) state_nxt = CLEAR;
      CLEAR:  if (!run) state_nxt = IDLE;
              else if (cnt == CLR_LAST) state_nxt = GATE;
      GATE:   if (!run) state_nxt = IDLE;
              else if (cnt == gate_last) state_nxt = SETTLE;
      SETTLE: state_nxt = LATCH;
      LATCH:  if (cnt == LAT_LAST) state_nxt = run ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      act_range <= 2'd0;
      range_out <= 2'd0;
      rst_hold  <= 1'b1;
    end else begin
      state    <= state_nxt;
      rst_hold <= 1'b0;
      if (state_nxt != state || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state_nxt == CLEAR && state != CLEAR)
        act_range <= (range_sel == 2'd3) ? 2'd0 : range_sel;
      if (state_nxt == LATCH && state != LATCH)
        range_out <= act_range;
    end
  end

  // Strobes decode directly from state so an async reset clears them at once.
  assign cnt_clr   = (state == CLEAR);
  assign cnt_en    = (state == GATE);
  assign latch_out = (state == LATCH);
  assign busy      = (state != IDLE);
  assign done      = (state == LATCH) && (cnt == LAT_LAST);

endmodule
